tmds_channel_encoder: RTL and testbench

- Full DVI 1.0 TMDS 8b/10b encoder for one colour channel, with running-disparity tracking, replacing the fixed eight-symbol lookup.
- Sits directly upstream of the 10-bit symbol latch/serializer in the clk_x5 domain.
- Advances on the one-in-five pixel strobe.
- Three instances (red, green, blue) feed the c2/c1/c0 symbol registers; ctrl carries {vsync,hsync} on the blue instance and 2'b00 on the others.

---
 rtl/tmds_channel_encoder.sv | 111 +++++++++++
 tb/tb_tmds_channel_encoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_encoder.sv
// DVI TMDS 8b/10b encoder for one colour channel with running-disparity tracking.
// Two pixel-strobe stages: transition minimisation, then DC balancing.
module tmds_channel_encoder #(
  parameter logic [1:0] RESET_CTRL = 2'b00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              de,
  input  logic [1:0]        ctrl,
  input  logic [7:0]        data,
  output logic [9:0]        symbol,
  output logic signed [4:0] disparity
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] s;
    s = 10'b1101010100;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  // qm[8] records the chain type (1 = XOR) so the decoder can undo it.
  function automatic logic [8:0] minimize_transitions(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8]    = ~use_xnor;
    return qm;
  endfunction

  logic              de_p1_q, de_p1_d;
  logic [1:0]        ctrl_p1_q, ctrl_p1_d;
  logic [8:0]        qm_p1_q, qm_p1_d;
  logic [9:0]        sym_p2_q, sym_p2_d;
  logic signed [4:0] cnt_p2_q, cnt_p2_d;

  logic [3:0]        n1_p2;
  logic signed [5:0] bal_wide_p2;
  logic signed [4:0] bal_p2;
  logic signed [4:0] two_q8_p2, two_nq8_p2;
  logic              qm8_p2;

  // ---- stage 1: transition-minimised q_m ----
  assign de_p1_d   = de;
  assign ctrl_p1_d = ctrl;
  assign qm_p1_d   = minimize_transitions(data);

  // ---- stage 2: DC balance against running disparity ----
  assign qm8_p2      = qm_p1_q[8];
  assign n1_p2       = popcount8(qm_p1_q[7:0]);
  assign bal_wide_p2 = $signed({1'b0, n1_p2, 1'b0}) - 6'sd8;
  assign bal_p2      = bal_wide_p2[4:0];
  assign two_q8_p2   = {3'b000, qm8_p2, 1'b0};
  assign two_nq8_p2  = {3'b000, ~qm8_p2, 1'b0};

  always_comb begin
    sym_p2_d = sym_p2_q;
    cnt_p2_d = cnt_p2_q;
    if (!de_p1_q) begin
      sym_p2_d = ctrl_symbol(ctrl_p1_q);
      cnt_p2_d = 5'sd0;
    end else if ((cnt_p2_q == 5'sd0) || (n1_p2 == 4'd4)) begin
      sym_p2_d = {~qm8_p2, qm8_p2, qm8_p2 ? qm_p1_q[7:0] : ~qm_p1_q[7:0]};
      cnt_p2_d = qm8_p2 ? (cnt_p2_q + bal_p2) : (cnt_p2_q - bal_p2);
    end else if (((cnt_p2_q > 5'sd0) && (bal_p2 > 5'sd0)) ||
                 ((cnt_p2_q < 5'sd0) && (bal_p2 < 5'sd0))) begin
      sym_p2_d = {1'b1, qm8_p2, ~qm_p1_q[7:0]};
      cnt_p2_d = cnt_p2_q + two_q8_p2 - bal_p2;
    end else begin
      sym_p2_d = {1'b0, qm8_p2, qm_p1_q[7:0]};
      cnt_p2_d = cnt_p2_q - two_nq8_p2 + bal_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_p1_q   <= 1'b0;
      ctrl_p1_q <= 2'b00;
      qm_p1_q   <= 9'd0;
      sym_p2_q  <= ctrl_symbol(RESET_CTRL);
      cnt_p2_q  <= 5'sd0;
    end else if (pix_en) begin
      de_p1_q   <= de_p1_d;
      ctrl_p1_q <= ctrl_p1_d;
      qm_p1_q   <= qm_p1_d;
      sym_p2_q  <= sym_p2_d;
      cnt_p2_q  <= cnt_p2_d;
    end
  end

  assign symbol    = sym_p2_q;
  assign disparity = cnt_p2_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: directed cases plus randomised
// traffic against a disparity-driven reference encoder.
module tb_tmds_channel_encoder;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pix_en = 1'b0;
  logic              de = 1'b0;
  logic [1:0]        ctrl = 2'b00;
  logic [7:0]        data = 8'h00;
  logic [9:0]        symbol;
  logic signed [4:0] disparity;

  always #4 clk = ~clk;

  tmds_channel_encoder #(.RESET_CTRL(2'b00)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .de(de), .ctrl(ctrl),
    .data(data), .symbol(symbol), .disparity(disparity)
  );

  typedef struct {
    int         due;
    bit         de;
    logic [7:0] b;
    logic [9:0] sym;
    int         disp;
  } exp_t;

  localparam logic [9:0] C0 = 10'b1101010100;
  localparam logic [9:0] C1 = 10'b0010101011;
  localparam logic [9:0] C2 = 10'b0101010100;
  localparam logic [9:0] C3 = 10'b1010101011;

  exp_t       sb[$];
  exp_t       cur;
  int         n_cmp = 0, n_fail = 0;
  int         strobe_cnt = 0;
  int         run_sum = 0;
  int         m_cnt = 0;
  logic [9:0] hold_sym;
  int         hold_disp;
  bit         hold_valid = 0;
  bit         was_s, was_r;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at strobe %0d",
               name, act, act, exp, exp, strobe_cnt);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~s[8];
    return o;
  endfunction

  // Reference: pick inversion to steer the line's accumulated ones-minus-zeros
  // toward zero; the counter is literally that running sum of emitted symbols.
  function automatic void model_enc(input bit d, input logic [1:0] c, input logic [7:0] b,
                                    inout int cnt, output logic [9:0] sym);
    logic [9:0] tab [4];
    logic [8:0] qm;
    int         n1d, n1;
    bit         use_xnor, inv;
    tab = '{C0, C1, C2, C3};
    if (!d) begin
      sym = tab[c];
      cnt = 0;
      return;
    end
    n1d      = $countones(b);
    use_xnor = (n1d > 4) || (n1d == 4 && b[0] == 1'b0);
    qm[0]    = b[0];
    for (int i = 1; i < 8; i++) qm[i] = b[i] ^ qm[i-1] ^ use_xnor;
    qm[8]    = !use_xnor;
    n1       = $countones(qm[7:0]);
    if (cnt == 0 || n1 == 4) inv = !qm[8];
    else                     inv = ((cnt > 0) == (n1 > 4));
    sym = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    cnt = cnt + 2 * $countones(sym) - 10;
  endfunction

  // Monitor: checks outputs on every edge, popping the scoreboard on strobes.
  always @(posedge clk) begin
    was_r = reset;
    was_s = pix_en && !reset;
    #1;
    if (was_r) begin
      check("reset_symbol", symbol, C0);
      check("reset_disparity", disparity, 0);
      hold_sym = C0; hold_disp = 0; hold_valid = 1; run_sum = 0;
    end else if (was_s) begin
      strobe_cnt++;
      while (sb.size() > 0 && sb[0].due < strobe_cnt) begin
        check("missed_output", strobe_cnt, sb[0].due);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == strobe_cnt) begin
        cur = sb.pop_front();
        check("symbol", symbol, cur.sym);
        check("disparity", disparity, cur.disp);
        if (cur.de) begin
          run_sum = run_sum + 2 * $countones(symbol) - 10;
          check("ones_minus_zeros", disparity, run_sum);
          check("decoded_byte", decode(symbol), cur.b);
          check("disparity_bound", int'(disparity >= -10 && disparity <= 10), 1);
        end else begin
          run_sum = 0;
        end
        hold_sym = cur.sym; hold_disp = cur.disp; hold_valid = 1;
      end else begin
        hold_valid = 0;
      end
    end else if (hold_valid) begin
      check("hold_symbol", symbol, hold_sym);
      check("hold_disparity", disparity, hold_disp);
    end
  end

  // One pixel period: strobe for one cycle, then scramble inputs while idle.
  task automatic strobe(input bit d, input logic [1:0] c, input logic [7:0] b);
    @(negedge clk);
    de = d; ctrl = c; data = b; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    de = 1'($urandom_range(0, 1)); ctrl = 2'($urandom_range(0, 3)); data = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);
  endtask

  task automatic push_exp(input bit d, input logic [7:0] b, input logic [9:0] sym, input int disp);
    exp_t e;
    e.due = strobe_cnt + 1; e.de = d; e.b = b; e.sym = sym; e.disp = disp;
    sb.push_back(e);
  endtask

  task automatic model_strobe(input bit d, input logic [1:0] c, input logic [7:0] b);
    logic [9:0] s;
    strobe(d, c, b);
    model_enc(d, c, b, m_cnt, s);
    push_exp(d, b, s, m_cnt);
  endtask

  // Reset with pix_en high and live data; stage 1 then holds de=0/ctrl=00.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pix_en = 1'b1; de = 1'b1; data = 8'hA5;
    @(negedge clk);
    reset = 1'b0; pix_en = 1'b0;
    sb.delete();
    m_cnt = 0;
    push_exp(1'b0, 8'h00, C0, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    strobe(0, 2'b00, 8'h00); push_exp(0, 8'h00, C0, 0);
    strobe(0, 2'b01, 8'h00); push_exp(0, 8'h00, C1, 0);
    strobe(0, 2'b10, 8'h00); push_exp(0, 8'h00, C2, 0);
    strobe(0, 2'b11, 8'h00); push_exp(0, 8'h00, C3, 0);

    strobe(1, 2'b00, 8'h00); push_exp(1, 8'h00, 10'b0100000000, -8);
    strobe(1, 2'b00, 8'h00); push_exp(1, 8'h00, 10'b1111111111, 2);
    strobe(1, 2'b00, 8'h00); push_exp(1, 8'h00, 10'b0100000000, -6);
    strobe(0, 2'b00, 8'h00); push_exp(0, 8'h00, C0, 0);
    strobe(1, 2'b00, 8'hFF); push_exp(1, 8'hFF, 10'b1000000000, -8);
    strobe(0, 2'b00, 8'h00); push_exp(0, 8'h00, C0, 0);
    strobe(1, 2'b00, 8'h00); push_exp(1, 8'h00, 10'b0100000000, -8);
    strobe(0, 2'b00, 8'h00); push_exp(0, 8'h00, C0, 0);
    strobe(1, 2'b00, 8'h00); push_exp(1, 8'h00, 10'b0100000000, -8);
    strobe(1, 2'b00, 8'h00); push_exp(1, 8'h00, 10'b1111111111, 2);

    do_reset();
    strobe(1, 2'b00, 8'h00); push_exp(1, 8'h00, 10'b0100000000, -8);

    do_reset();
    for (int i = 0; i < 10000; i++)
      model_strobe(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

    strobe(0, 2'b00, 8'h00);
    strobe(0, 2'b00, 8'h00);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
